alu_vec_pipe: RTL and testbench
===============================

// Module: alu_vec_pipe
// PURPOSE
//  Pipelined, parametrised SIMD fixed-point ALU; successor to the combinational vector ALU.
//  Operates on LANES signed Qm.FRAC_W lanes packed in one word, with a valid/ready handshake.
//  Sits between vector register-file read and writeback in the vector execute stage.
//  Adds scalar broadcast, per-lane NZCV flags and backpressure.
// PARAMETERS
//  LANES   16  number of lanes (lane 0 = bits [LANE_W-1:0])
//  LANE_W  16  lane width, two's complement
//  FRAC_W   8  fractional bits for MUL (Q8.8 by default)
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  in_valid     in   1              operand bundle valid
//  in_ready     out  1              block accepts bundle this cycle
//  a            in   LANES*LANE_W   operand A
//  b            in   LANES*LANE_W   operand B
//  opcode       in   3              operation select (see BEHAVIOUR)
//  flag_scalar  in   1              1: b lane 0 broadcast to all lanes
//  out_valid    out  1              result valid
//  out_ready    in   1              consumer accepts result
//  result       out  LANES*LANE_W   lane results
//  flags        out  LANES*4        lane i flags at [4i+3:4i] = {N,Z,C,V}
// BEHAVIOUR
//  - Opcodes: 000 ADD, 001 SUB (a-b), 010 MUL, 011 AND, 100 OR, 101 XOR, 110 MIN, 111 MAX (signed).
//  - MUL: full 2*LANE_W signed product; result = product[FRAC_W+LANE_W-1:FRAC_W] (truncate).
//  - C: ADD = unsigned carry-out; SUB = 1 when a>=b unsigned (no borrow); all others 0.
//  - V: ADD/SUB = signed overflow; MUL = product bits above FRAC_W+LANE_W-1 are not a sign-extension; others 0.
//  - N = MSB of final lane result; Z = final lane result == 0.
//  - Pipeline: S1 registers operands, opcode and raw results (sums, products);
//    S2 registers normalised result and flags. Latency 2 cycles, accept-to-out_valid.
//  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
//  - stall = out_valid && !out_ready; in_ready = !stall. While stalled, S1 and S2 hold and outputs stay stable.
//  - No bubble insertion: full throughput of 1 op/cycle when out_ready is held high.
//  - Empty pipe: out_valid=0; result/flags hold their last value (don't-care for consumers).
//  - flag_scalar is sampled with the bundle; it applies per transaction only.
//  - Reset (asserted at any time, including mid-stream): S1/S2 valid=0, out_valid=0, result=0, flags=0,
//    in_ready=1. In-flight bundles are discarded. Reset release is synchronised by the pipeline regs only.
//  - Simultaneous in-transfer and out-transfer in the same cycle: both occur, no loss or duplication.
// CONFIGURATION
//  ALU_VEC_SAT_EN defined: ADD/SUB/MUL lanes with V=1 saturate to the signed extreme
//    (0x7FFF positive, 0x8000 negative for LANE_W=16).
//    V stays 1; N and Z are computed from the saturated value.
//  Not defined: results wrap (two's complement truncation); V still reported.
// TESTING
//  T1 MUL, flag_scalar=0: a lane15..9 = 0180,0140,0380,0180,0080,0300,0140, lane0=0140;
//     b lane15..9 = FE40,0180,0200,0340,05C0,FF80,FE80, lane0=FE80
//     -> lane15=FD60 flags 8, lane0=FE20 flags 8, lane14=01E0 flags 0; zero lanes=0000 flags 4.
//  T2 same operands, flag_scalar=1 -> every lane multiplies by FE80: lane15=FDC0, lane14=FE20,
//     lane0=FE20; zero lanes flags 4.
//  T3 ADD lane0 7F00+0200 -> no SAT_EN: 8100 flags 9; SAT_EN: 7FFF flags 1.
//     SUB lane0 0100-0100 -> 0000 flags 6 (Z,C).
//  T4 Stream 4 back-to-back ops with out_ready=1 -> out_valid 2 cycles after first accept,
//     4 consecutive results in order. Repeat with out_ready=0 for 3 cycles mid-stream
//     -> in_ready=0 during stall, outputs stable, no drop or duplicate.
//  T5 Assert rst_n low while 2 ops are in flight -> out_valid=0, result=0, flags=0 immediately.
//     After release, next op returns its own correct result only.
//  T6 MIN/MAX and logic ops: lane0 a=8000 b=0001 -> MIN=8000 flags 8, MAX=0001 flags 0,
//     XOR=8001 flags 8.

Source files
------------

// File: rtl/alu_vec_pipe.sv
// alu_vec_pipe: two-stage pipelined SIMD fixed-point ALU with valid/ready handshake.
// LANES signed lanes of LANE_W bits; MUL treats lanes as Q(LANE_W-FRAC_W).FRAC_W.
// Per-lane {N,Z,C,V} flags, optional scalar broadcast of b lane 0, full-throughput backpressure.
// Build option: define ALU_VEC_SAT_EN to saturate overflowing ADD/SUB/MUL lanes
// (otherwise results wrap and V is still reported).
module alu_vec_pipe #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] a,
    input  logic [LANES*LANE_W-1:0] b,
    input  logic [2:0]              opcode,
    input  logic                    flag_scalar,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] result,
    output logic [LANES*4-1:0]      flags
);

    localparam int RAW_W = 2 * LANE_W;
    localparam int VEC_W = LANES * LANE_W;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_MIN = 3'b110,
        OP_MAX = 3'b111
    } op_e;

    logic                   w_stall;
    logic                   w_advance;
    logic [LANES*RAW_W-1:0] w_rawAll;
    logic [LANES-1:0]       w_signA;
    logic [LANES-1:0]       w_signB;
    logic [VEC_W-1:0]       w_resAll;
    logic [LANES*4-1:0]     w_flagAll;

    logic                   r_s1Valid;
    op_e                    r_s1Op;
    logic [LANES*RAW_W-1:0] r_s1Raw;
    logic [LANES-1:0]       r_s1SignA;
    logic [LANES-1:0]       r_s1SignB;

    // The only reason to stop is an unconsumed result; both stages then freeze together.
    assign w_stall   = out_valid && !out_ready;
    assign w_advance = !w_stall;
    assign in_ready  = w_advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0]              w_laneA;
        logic [LANE_W-1:0]              w_laneB;
        logic [LANE_W:0]                w_sum;
        logic [LANE_W:0]                w_diff;
        logic [RAW_W-1:0]               w_prod;
        logic [RAW_W-1:0]               w_raw;
        logic [RAW_W-1:0]               w_s1Raw;
        logic [RAW_W-FRAC_W-LANE_W:0]   w_upper;
        logic [LANE_W-1:0]              w_wrap;
        logic [LANE_W-1:0]              w_final;
        logic                           w_c;
        logic                           w_v;

        assign w_laneA = a[i*LANE_W +: LANE_W];
        assign w_laneB = flag_scalar ? b[LANE_W-1:0] : b[i*LANE_W +: LANE_W];
        assign w_sum   = {1'b0, w_laneA} + {1'b0, w_laneB};
        assign w_diff  = {1'b0, w_laneA} + {1'b0, ~w_laneB} + {{LANE_W{1'b0}}, 1'b1};
        assign w_prod  = $signed({{LANE_W{w_laneA[LANE_W-1]}}, w_laneA})
                       * $signed({{LANE_W{w_laneB[LANE_W-1]}}, w_laneB});

        // Stage-1 raw value: carry-extended sum/difference, full product, or finished bitwise/min/max lane.
        always_comb begin
            w_raw = '0;
            case (op_e'(opcode))
                OP_ADD:  w_raw = {{(RAW_W-LANE_W-1){1'b0}}, w_sum};
                OP_SUB:  w_raw = {{(RAW_W-LANE_W-1){1'b0}}, w_diff};
                OP_MUL:  w_raw = w_prod;
                OP_AND:  w_raw = {{LANE_W{1'b0}}, w_laneA & w_laneB};
                OP_OR:   w_raw = {{LANE_W{1'b0}}, w_laneA | w_laneB};
                OP_XOR:  w_raw = {{LANE_W{1'b0}}, w_laneA ^ w_laneB};
                OP_MIN:  w_raw = {{LANE_W{1'b0}}, ($signed(w_laneA) < $signed(w_laneB)) ? w_laneA : w_laneB};
                OP_MAX:  w_raw = {{LANE_W{1'b0}}, ($signed(w_laneA) > $signed(w_laneB)) ? w_laneA : w_laneB};
                default: w_raw = '0;
            endcase
        end

        assign w_rawAll[i*RAW_W +: RAW_W] = w_raw;
        assign w_signA[i] = w_laneA[LANE_W-1];
        assign w_signB[i] = w_laneB[LANE_W-1];

        assign w_s1Raw = r_s1Raw[i*RAW_W +: RAW_W];
        assign w_upper = w_s1Raw[RAW_W-1:FRAC_W+LANE_W-1];

        // Stage-2 normalisation: pick the lane field of the raw value and derive carry and overflow.
        always_comb begin
            w_wrap = w_s1Raw[LANE_W-1:0];
            w_c    = 1'b0;
            w_v    = 1'b0;
            case (r_s1Op)
                OP_ADD: begin
                    w_c = w_s1Raw[LANE_W];
                    w_v = (r_s1SignA[i] == r_s1SignB[i]) && (w_s1Raw[LANE_W-1] != r_s1SignA[i]);
                end
                OP_SUB: begin
                    w_c = w_s1Raw[LANE_W];
                    w_v = (r_s1SignA[i] != r_s1SignB[i]) && (w_s1Raw[LANE_W-1] != r_s1SignA[i]);
                end
                OP_MUL: begin
                    w_wrap = w_s1Raw[FRAC_W+LANE_W-1:FRAC_W];
                    w_v    = !((&w_upper) || !(|w_upper));
                end
                default: begin
                    w_c = 1'b0;
                    w_v = 1'b0;
                end
            endcase
        end

`ifdef ALU_VEC_SAT_EN
        logic w_negOvf;

        // Overflow direction: the true ADD/SUB result carries operand A's sign, MUL carries the product's.
        always_comb begin
            w_negOvf = 1'b0;
            case (r_s1Op)
                OP_ADD, OP_SUB: w_negOvf = r_s1SignA[i];
                OP_MUL:         w_negOvf = w_s1Raw[RAW_W-1];
                default:        w_negOvf = 1'b0;
            endcase
        end

        assign w_final = !w_v     ? w_wrap :
                         w_negOvf ? {1'b1, {(LANE_W-1){1'b0}}} :
                                    {1'b0, {(LANE_W-1){1'b1}}};
`else
        assign w_final = w_wrap;
`endif

        assign w_resAll[i*LANE_W +: LANE_W] = w_final;
        assign w_flagAll[i*4 +: 4] = {w_final[LANE_W-1], (w_final == '0), w_c, w_v};
    end

    // S1 captures accepted bundles as raw results, S2 publishes normalised result/flags; both hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Op    <= OP_ADD;
            r_s1Raw   <= '0;
            r_s1SignA <= '0;
            r_s1SignB <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_advance) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Op    <= op_e'(opcode);
                r_s1Raw   <= w_rawAll;
                r_s1SignA <= w_signA;
                r_s1SignB <= w_signB;
            end
            out_valid <= r_s1Valid;
            if (r_s1Valid) begin
                result <= w_resAll;
                flags  <= w_flagAll;
            end
        end
    end

endmodule

// File: tb/tb_alu_vec_pipe.sv
// tb_alu_vec_pipe: randomized and directed stimulus for alu_vec_pipe, checked against
// an arithmetic lane model; expected bundles are queued at acceptance and retired on output transfer.
module tb_alu_vec_pipe;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int FRAC_W = 8;
    localparam int VW     = LANES * LANE_W;
    localparam int FW     = LANES * 4;

    typedef struct {
        logic [VW-1:0] res;
        logic [FW-1:0] flg;
        int            acceptCycle;
        bit            latCheck;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] a = '0;
    logic [VW-1:0] b = '0;
    logic [2:0]    opcode = 3'd0;
    logic          flag_scalar = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result;
    logic [FW-1:0] flags;

    exp_t          expQ[$];
    int            testCount = 0;
    int            failCount = 0;
    int            cycleCount = 0;
    int            readyMode = 0;
    bit            latMode = 1'b0;
    logic [VW-1:0] obsRes = '0;
    logic [FW-1:0] obsFlg = '0;
    logic [VW-1:0] prevRes = '0;
    logic [FW-1:0] prevFlg = '0;
    bit            prevStall = 1'b0;

    alu_vec_pipe #(
        .LANES (LANES),
        .LANE_W(LANE_W),
        .FRAC_W(FRAC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .flag_scalar(flag_scalar),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Lane semantics from plain integer arithmetic on the true (unbounded) values.
    function automatic void refModel(input logic [VW-1:0] av, input logic [VW-1:0] bv, input logic [2:0] op,
                                     input logic fs, output logic [VW-1:0] res, output logic [FW-1:0] flg);
        res = '0;
        flg = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [15:0] la, lb, r16;
            longint      sa, sb, ua, ub, full;
            bit          c, v;
            la   = av[i*16 +: 16];
            lb   = fs ? bv[15:0] : bv[i*16 +: 16];
            sa   = longint'($signed(la));
            sb   = longint'($signed(lb));
            ua   = longint'({48'b0, la});
            ub   = longint'({48'b0, lb});
            c    = 1'b0;
            v    = 1'b0;
            full = 0;
            case (op)
                3'd0: begin full = sa + sb; c = (ua + ub) > 65535; end
                3'd1: begin full = sa - sb; c = (ua >= ub); end
                3'd2: full = (sa * sb) >>> FRAC_W;
                3'd3: full = longint'({48'b0, la & lb});
                3'd4: full = longint'({48'b0, la | lb});
                3'd5: full = longint'({48'b0, la ^ lb});
                3'd6: full = (sa < sb) ? sa : sb;
                default: full = (sa > sb) ? sa : sb;
            endcase
            if (op <= 3'd2) v = (full > 32767) || (full < -32768);
            r16 = full[15:0];
`ifdef ALU_VEC_SAT_EN
            if (v) r16 = (full < 0) ? 16'h8000 : 16'h7FFF;
`endif
            res[i*16 +: 16] = r16;
            flg[i*4 +: 4]   = {r16[15], r16 == 16'h0000, c, v};
        end
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0: v[i*16 +: 16] = 16'($urandom_range(0, 2047)) - 16'd1024;
                1: begin
                    case ($urandom_range(0, 3))
                        0: v[i*16 +: 16] = 16'h7FFF;
                        1: v[i*16 +: 16] = 16'h8000;
                        2: v[i*16 +: 16] = 16'h0000;
                        default: v[i*16 +: 16] = 16'hFFFF;
                    endcase
                end
                default: v[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Present one bundle (called just after a rising edge) and hold it until the block takes it.
    task automatic applyStimulus(input logic [VW-1:0] av, input logic [VW-1:0] bv, input logic [2:0] op,
                                 input logic fs);
        exp_t e;
        int   waitCycles;
        bit   done;
        waitCycles = 0;
        done = 1'b0;
        refModel(av, bv, op, fs, e.res, e.flg);
        e.latCheck = latMode;
        e.acceptCycle = 0;
        a = av;
        b = bv;
        opcode = op;
        flag_scalar = fs;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.acceptCycle = cycleCount;
                expQ.push_back(e);
                done = 1'b1;
            end else if (waitCycles >= 50) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
                in_valid = 1'b0;
                done = 1'b1;
            end
            waitCycles++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Issue one bundle into an empty pipe and capture the output it produces.
    task automatic runDirected(input logic [VW-1:0] av, input logic [VW-1:0] bv, input logic [2:0] op,
                               input logic fs);
        int n;
        n = 0;
        applyStimulus(av, bv, op, fs);
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        testCount++;
        if (!out_valid) begin
            failCount++;
            $display("[TB] FAIL out_timeout: out_valid %0b, expected 1", out_valid);
        end
        obsRes = result;
        obsFlg = flags;
        @(posedge clk);
        #1;
    endtask

    task automatic checkLane(input string name, input int lane, input logic [15:0] expRes, input logic [3:0] expFlg);
        checkOutput({name, "_res"}, VW'(obsRes[lane*16 +: 16]), VW'(expRes));
        checkOutput({name, "_flags"}, VW'(obsFlg[lane*4 +: 4]), VW'(expFlg));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        testCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
        end
    endtask

    // Consumer side: 0 = always ready, 1 = never ready, otherwise ready about 3 cycles in 4.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output watcher: retire expected bundles on transfer, and police stall behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_result_hold", result, prevRes);
                    checkOutput("stall_flags_hold", VW'(flags), VW'(prevFlg));
                    checkOutput("stall_valid_hold", VW'(out_valid), VW'(1'b1));
                end
                checkOutput("in_ready", VW'(in_ready), VW'(!(out_valid && !out_ready)));
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        testCount++;
                        failCount++;
                        $display("[TB] FAIL unexpected_output: result %0h with no outstanding bundle", result);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sb_result", result, e.res);
                        checkOutput("sb_flags", VW'(flags), VW'(e.flg));
                        if (e.latCheck)
                            checkOutput("latency", VW'(cycleCount - e.acceptCycle), VW'(2));
                    end
                end
                prevStall = out_valid && !out_ready;
                prevRes   = result;
                prevFlg   = flags;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VW-1:0] t1a, t1b, t3a, t3b, t6a, t6b;
        t1a = {16'h0180, 16'h0140, 16'h0380, 16'h0180, 16'h0080, 16'h0300, 16'h0140, 128'h0, 16'h0140};
        t1b = {16'hFE40, 16'h0180, 16'h0200, 16'h0340, 16'h05C0, 16'hFF80, 16'hFE80, 128'h0, 16'hFE80};
        readyMode = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", VW'(out_valid), VW'(1'b0));
        checkOutput("reset_result", result, '0);
        checkOutput("reset_flags", VW'(flags), '0);
        checkOutput("reset_in_ready", VW'(in_ready), VW'(1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: per-lane Q8.8 multiply
        runDirected(t1a, t1b, 3'd2, 1'b0);
        checkLane("t1_lane15", 15, 16'hFD60, 4'h8);
        checkLane("t1_lane14", 14, 16'h01E0, 4'h0);
        checkLane("t1_lane0", 0, 16'hFE20, 4'h8);
        checkLane("t1_lane4", 4, 16'h0000, 4'h4);

        // T2: same operands with b lane 0 broadcast
        runDirected(t1a, t1b, 3'd2, 1'b1);
        checkLane("t2_lane15", 15, 16'hFDC0, 4'h8);
        checkLane("t2_lane14", 14, 16'hFE20, 4'h8);
        checkLane("t2_lane0", 0, 16'hFE20, 4'h8);
        checkLane("t2_lane5", 5, 16'h0000, 4'h4);

        // T3: signed overflow on ADD, equal operands on SUB
        t3a = {240'h0, 16'h7F00};
        t3b = {240'h0, 16'h0200};
        runDirected(t3a, t3b, 3'd0, 1'b0);
`ifdef ALU_VEC_SAT_EN
        checkLane("t3_add_lane0", 0, 16'h7FFF, 4'h1);
`else
        checkLane("t3_add_lane0", 0, 16'h8100, 4'h9);
`endif
        checkLane("t3_add_lane3", 3, 16'h0000, 4'h4);
        t3a = {240'h0, 16'h0100};
        t3b = {240'h0, 16'h0100};
        runDirected(t3a, t3b, 3'd1, 1'b0);
        checkLane("t3_sub_lane0", 0, 16'h0000, 4'h6);

        // T6: signed MIN/MAX and XOR at the most negative value
        t6a = {240'h0, 16'h8000};
        t6b = {240'h0, 16'h0001};
        runDirected(t6a, t6b, 3'd6, 1'b0);
        checkLane("t6_min_lane0", 0, 16'h8000, 4'h8);
        runDirected(t6a, t6b, 3'd7, 1'b0);
        checkLane("t6_max_lane0", 0, 16'h0001, 4'h0);
        runDirected(t6a, t6b, 3'd5, 1'b0);
        checkLane("t6_xor_lane0", 0, 16'h8001, 4'h8);

        // T4: back-to-back stream with the consumer always ready
        latMode = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(randVec(), randVec(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        latMode = 1'b0;
        waitDrain();

        // T4: consumer stalls for 3 cycles while a stream is in flight
        fork
            begin
                for (int i = 0; i < 6; i++)
                    applyStimulus(randVec(), randVec(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (3) @(posedge clk);
                readyMode = 1;
                repeat (3) @(posedge clk);
                readyMode = 0;
            end
        join
        waitDrain();

        // Random traffic with random consumer backpressure and input gaps
        readyMode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(randVec(), randVec(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        readyMode = 0;
        waitDrain();

        // T5: reset with two bundles in flight, then one clean bundle
        @(posedge clk);
        #1;
        applyStimulus(randVec(), randVec(), 3'd0, 1'b0);
        applyStimulus(randVec(), randVec(), 3'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_out_valid", VW'(out_valid), VW'(1'b0));
        checkOutput("t5_result", result, '0);
        checkOutput("t5_flags", VW'(flags), '0);
        checkOutput("t5_in_ready", VW'(in_ready), VW'(1'b1));
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runDirected(t3a, t3b, 3'd1, 1'b0);
        checkLane("t5_after_lane0", 0, 16'h0000, 4'h6);
        waitDrain();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
